multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control unit that sequences the ARMv4-subset datapath: instruction fetch, register read, ALU, data memory and writeback, sharing one memory port and one ALU across several cycles per instruction. It sits beside the datapath registers (IR, PC, data register, ALU-out register). It decodes the latched instruction fields into per-state mux selects and write enables. It holds the NZCV flag register and evaluates the condition field.

## Interface
- No parameters.
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous active-low reset
- cond  in  4  IR[31:28]
- op  in  2  IR[27:26]
- funct  in  6  IR[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- rd  in  4  IR[15:12]
- aluflags  in  4  NZCV from ALU, current cycle
- irwrite  out  1  load IR from memory read data
- pcwrite  out  1  load PC from result bus
- adrsrc  out  1  memory address: 0=PC, 1=ALU-out register
- memwrite  out  1  data memory write enable
- regwrite  out  1  register file write enable
- alusrca  out  1  0=rd1, 1=PC
- alusrcb  out  2  00=rd2, 01=extimm, 10=constant 4
- alucontrol  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- resultsrc  out  2  00=ALU-out register, 01=data register, 10=ALU result
- immsrc  out  2  00=8-bit zero-ext, 01=12-bit zero-ext, 10=24-bit branch
- regsrc  out  2  [0]: ra1=R15; [1]: ra2=rd
- flags  out  4  registered NZCV
- state  out  4  current state encoding, for debug LEDs

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 go to FETCH next cycle with all enables 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op=01→MEMADR; op=00 with funct[5]=0→EXECR; op=00 with funct[5]=1→EXECI; op=10→BRANCH; op=11→FETCH (undefined instruction, NOP).
  - MEMADR: funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH.
  - BRANCH→FETCH.
- Moore outputs per state; unlisted outputs are 0:
  - FETCH: irwrite=1, pcwrite=1, alusrca=1, alusrcb=10, ADD, resultsrc=10.
  - DECODE: alusrca=1, alusrcb=10, ADD, resultsrc=10 (R15 reads PC+8).
  - MEMADR: alusrcb=01, ADD.
  - MEMRD: adrsrc=1.
  - MEMWB: resultsrc=01, regwrite.
  - MEMWR: adrsrc=1, memwrite.
  - EXECR: alusrcb=00, decoded op.
  - EXECI: alusrcb=01, decoded op.
  - ALUWB: resultsrc=00, regwrite.
  - BRANCH: alusrcb=01, ADD, resultsrc=10, pcwrite.
- cmd decode:
  - 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR.
  - 1010 (CMP)→SUB; ALUWB suppresses regwrite.
  - Any other cmd→ADD.
- immsrc and regsrc are combinational from op:
  - op=00: immsrc=00.
  - op=01: immsrc=01, regsrc[1]=1.
  - op=10: immsrc=10, regsrc[0]=1.
- Condition: condex is evaluated in DECODE from flags and registered into condex_q at the DECODE→next edge.
  - Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL per ARMv4.
  - 1111 is never executed.
- condex_q=0 blocks regwrite, memwrite, the BRANCH pcwrite and any flag update. The state sequence is unchanged.
- rd=15 in MEMWB or ALUWB (condex_q=1, not CMP): pcwrite=1, regwrite=0.
- Flag update occurs at the EXECR/EXECI→ALUWB edge when funct[0]=1 and condex_q=1.
  - N and Z always load from aluflags.
  - C and V load only for ADD/SUB/CMP; for AND/ORR they hold.

## Timing
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, undefined 2.
- Async reset: state=FETCH, flags=0000, condex_q=0.
  - While reset_n=0, irwrite, pcwrite, memwrite and regwrite are forced 0.
  - Other outputs show FETCH values.
- Reset released: first FETCH enables assert in the first full cycle after the first rising edge with reset_n=1 sampled.
- Reset mid-instruction: immediate return to FETCH; no partial write completes after reset_n falls.
- Flags written in ALUWB of instruction k are visible to the DECODE of instruction k+1.

## Test plan
- Reset then ADD R1,R2,#5 (E2821005): state sequence 0,1,7,8,0; alucontrol=00, alusrcb=01 in EXECI; regwrite=1 only in ALUWB.
- CMP R1,R1 (E1510001) then ADDNE R3,R0,#1 (12803001): flags=0110 (Z,C set) after CMP; ADDNE runs 4 cycles with regwrite=0; CMP never asserts regwrite.
- LDR R4,[R0,#8] (E5904008): states 0,1,2,3,4; adrsrc=1 in MEMRD; resultsrc=01 with regwrite in MEMWB.
- STR R4,[R0,#12] (E580400C): states 0,1,2,5; memwrite=1 for exactly one cycle; regsrc=10.
- B with cond=AL (EA000002): states 0,1,9; pcwrite high in BRANCH; immsrc=10. Repeat with BEQ and Z=0: pcwrite low in BRANCH.
- Drop reset_n during MEMWR: state=0 and memwrite=0 combinationally; after release, fetch resumes cleanly with flags=0000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ARMv4-subset datapath: sequences fetch, decode, memory and ALU
// states, decodes IR fields into registered mux selects/enables, and owns the NZCV flags.
module multicycle_ctrl (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] alucontrol,
    output logic [1:0] resultsrc,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [3:0] flags,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic       run_q;
    logic [3:0] flags_q;
    logic       condex_q, condex_d, condex_eval;
    logic [1:0] alu_op;
    logic       is_cmp, rd_pc, flag_upd;

    logic       irwrite_d, pcwrite_d, adrsrc_d, memwrite_d, regwrite_d, alusrca_d;
    logic [1:0] alusrcb_d, alucontrol_d, resultsrc_d;

    assign is_cmp   = (funct[4:1] == 4'b1010);
    assign rd_pc    = (rd == 4'd15);
    assign condex_d = (state_q == StDecode) ? condex_eval : condex_q;
    assign flag_upd = run_q && funct[0] && condex_q &&
                      ((state_q == StExecR) || (state_q == StExecI));

    always_comb begin
        case (funct[4:1])
            4'b0100: alu_op = 2'b00;
            4'b0010: alu_op = 2'b01;
            4'b1010: alu_op = 2'b01;
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            default: alu_op = 2'b00;
        endcase
    end

    // flags_q = {N, Z, C, V}
    always_comb begin
        case (cond)
            4'b0000: condex_eval = flags_q[2];
            4'b0001: condex_eval = !flags_q[2];
            4'b0010: condex_eval = flags_q[1];
            4'b0011: condex_eval = !flags_q[1];
            4'b0100: condex_eval = flags_q[3];
            4'b0101: condex_eval = !flags_q[3];
            4'b0110: condex_eval = flags_q[0];
            4'b0111: condex_eval = !flags_q[0];
            4'b1000: condex_eval = flags_q[1] && !flags_q[2];
            4'b1001: condex_eval = !flags_q[1] || flags_q[2];
            4'b1010: condex_eval = (flags_q[3] == flags_q[0]);
            4'b1011: condex_eval = (flags_q[3] != flags_q[0]);
            4'b1100: condex_eval = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: condex_eval = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: condex_eval = 1'b1;
            default: condex_eval = 1'b0;
        endcase
    end

    // Hold FETCH for the first cycle after reset so its enables get one full cycle.
    always_comb begin
        state_d = StFetch;
        if (run_q) begin
            case (state_q)
                StFetch:  state_d = StDecode;
                StDecode: begin
                    case (op)
                        2'b01:   state_d = StMemAdr;
                        2'b00:   state_d = funct[5] ? StExecI : StExecR;
                        2'b10:   state_d = StBranch;
                        default: state_d = StFetch;
                    endcase
                end
                StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
                StMemRd:  state_d = StMemWb;
                StExecR:  state_d = StAluWb;
                StExecI:  state_d = StAluWb;
                default:  state_d = StFetch;
            endcase
        end
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        irwrite_d    = 1'b0;
        pcwrite_d    = 1'b0;
        adrsrc_d     = 1'b0;
        memwrite_d   = 1'b0;
        regwrite_d   = 1'b0;
        alusrca_d    = 1'b0;
        alusrcb_d    = 2'b00;
        alucontrol_d = 2'b00;
        resultsrc_d  = 2'b00;
        case (state_d)
            StFetch: begin
                irwrite_d   = 1'b1;
                pcwrite_d   = 1'b1;
                alusrca_d   = 1'b1;
                alusrcb_d   = 2'b10;
                resultsrc_d = 2'b10;
            end
            StDecode: begin
                alusrca_d   = 1'b1;
                alusrcb_d   = 2'b10;
                resultsrc_d = 2'b10;
            end
            StMemAdr: alusrcb_d = 2'b01;
            StMemRd:  adrsrc_d  = 1'b1;
            StMemWb: begin
                resultsrc_d = 2'b01;
                pcwrite_d   = condex_d && rd_pc;
                regwrite_d  = condex_d && !rd_pc;
            end
            StMemWr: begin
                adrsrc_d   = 1'b1;
                memwrite_d = condex_d;
            end
            StExecR:  alucontrol_d = alu_op;
            StExecI: begin
                alusrcb_d    = 2'b01;
                alucontrol_d = alu_op;
            end
            StAluWb: begin
                pcwrite_d  = condex_d && !is_cmp && rd_pc;
                regwrite_d = condex_d && !is_cmp && !rd_pc;
            end
            StBranch: begin
                alusrcb_d   = 2'b01;
                resultsrc_d = 2'b10;
                pcwrite_d   = condex_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StFetch;
            run_q      <= 1'b0;
            flags_q    <= 4'b0000;
            condex_q   <= 1'b0;
            irwrite    <= 1'b0;
            pcwrite    <= 1'b0;
            adrsrc     <= 1'b0;
            memwrite   <= 1'b0;
            regwrite   <= 1'b0;
            alusrca    <= 1'b1;
            alusrcb    <= 2'b10;
            alucontrol <= 2'b00;
            resultsrc  <= 2'b10;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            condex_q   <= condex_d;
            irwrite    <= irwrite_d;
            pcwrite    <= pcwrite_d;
            adrsrc     <= adrsrc_d;
            memwrite   <= memwrite_d;
            regwrite   <= regwrite_d;
            alusrca    <= alusrca_d;
            alusrcb    <= alusrcb_d;
            alucontrol <= alucontrol_d;
            resultsrc  <= resultsrc_d;
            if (flag_upd) begin
                flags_q[3:2] <= aluflags[3:2];
                // Logical ops leave carry and overflow untouched.
                if (!alu_op[1]) flags_q[1:0] <= aluflags[1:0];
            end
        end
    end

    always_comb begin
        immsrc = 2'b00;
        regsrc = 2'b00;
        case (op)
            2'b01: begin
                immsrc = 2'b01;
                regsrc = 2'b10;
            end
            2'b10: begin
                immsrc = 2'b10;
                regsrc = 2'b01;
            end
            default: ;
        endcase
    end

    assign flags = flags_q;
    assign state = state_q;

endmodule
